// File: rtl/pemcu_dbg_pkg.sv
// Shared constants and types for the PEMCU debug mailbox: address map,
// trace codes, FSM state encoding and the trace entry header layout.
package pemcu_dbg_pkg;

    localparam logic [15:0] ADDR_F100     = 16'hF100;
    localparam logic [11:0] ADDR_REG_PAGE = 12'hF10;
    localparam logic [15:0] ADDR_A100     = 16'hA100;
    localparam logic [15:0] ADDR_D000     = 16'hD000;
    localparam logic [15:0] ADDR_E000     = 16'hE000;

    localparam logic [4:0] CODE_FUNC = 5'h10;
    localparam logic [4:0] CODE_D000 = 5'h11;
    localparam logic [4:0] CODE_E000 = 5'h12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_REL  = 2'd2
    } fsm_state_t;

    // Code and data of a trace entry; the timestamp is appended at the width
    // chosen by the instantiating block.
    typedef struct packed {
        logic [4:0] code;
        logic [7:0] data;
    } trc_hdr_t;

    function automatic logic addr_hit(input logic [15:0] addr);
        return (addr[15:4] == ADDR_REG_PAGE) || (addr == ADDR_A100) ||
               (addr == ADDR_D000) || (addr == ADDR_E000);
    endfunction

endpackage

// File: rtl/pemcu_dbg_fifo.sv
// Single-clock synchronous FIFO. Accepts a push while full only when a pop
// happens in the same cycle; any other push while full is ignored.
module pemcu_dbg_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == LW'(DEPTH));
    assign empty = (count_r == {LW{1'b0}});
    assign level = count_r;

    // Qualify push/pop and present the head (zero when empty)
    always_comb begin
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (empty) begin
            dout = {WIDTH{1'b0}};
        end else begin
            dout = mem_r[rd_ptr_r];
        end
    end

    // Entry storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + LW'(1);
                2'b01:   count_r <= count_r - LW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/pemcu_dbg_mailbox.sv
// Debug mailbox on the PEMCU external bus: acks firmware debug accesses,
// keeps readback copies and queues every traced write with a timestamp.
module pemcu_dbg_mailbox
    import pemcu_dbg_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int TS_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     memaddr,
    input  logic            memwr,
    input  logic            memrd,
    input  logic [7:0]      memdatao,
    output logic [7:0]      memdatai,
    output logic            memack,
    output logic            hit,
    output logic            trc_valid,
    input  logic            trc_ready,
    output logic [4:0]      trc_code,
    output logic [7:0]      trc_data,
    output logic [TS_W-1:0] trc_ts,
    output logic            ovf,
    output logic [7:0]      ovf_cnt
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = $bits(trc_hdr_t) + TS_W;

    fsm_state_t      state_r;
    logic            memack_r;
    logic [7:0]      memdatai_r;
    logic [15:0]     req_addr_r;
    logic [7:0]      req_data_r;
    logic            req_wr_r;
    logic [7:0]      regs_r [16];
    logic [7:0]      func_code_r;
    logic [TS_W-1:0] ts_r;
    logic            ovf_r;
    logic [7:0]      ovf_cnt_r;

    logic            hit_s;
    logic            ack_wr_s;
    logic            trace_s;
    logic            ctrl_clr_s;
    logic            pop_s;
    logic            drop_s;
    trc_hdr_t        hdr_s;
    trc_hdr_t        head_hdr_s;
    logic [7:0]      rd_data_s;
    logic [7:0]      lvl_ext_s;
    logic [4:0]      lvl_sat_s;
    logic [ENT_W-1:0] fifo_dout_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [LVL_W-1:0] fifo_level_s;

    assign hit_s      = addr_hit(memaddr);
    assign hit        = hit_s;
    assign memack     = memack_r;
    assign memdatai   = memdatai_r;
    assign ovf        = ovf_r;
    assign ovf_cnt    = ovf_cnt_r;
    assign trc_valid  = !fifo_empty_s;
    assign head_hdr_s = fifo_dout_s[ENT_W-1:TS_W];
    assign trc_code   = head_hdr_s.code;
    assign trc_data   = head_hdr_s.data;
    assign trc_ts     = fifo_dout_s[TS_W-1:0];
    assign lvl_ext_s  = {{(8 - LVL_W){1'b0}}, fifo_level_s};

    // Readback value for the address currently on the bus
    always_comb begin
        if (lvl_ext_s > 8'd31) begin
            lvl_sat_s = 5'd31;
        end else begin
            lvl_sat_s = lvl_ext_s[4:0];
        end
        rd_data_s = 8'h00;
        if (memaddr[15:4] == ADDR_REG_PAGE) begin
            if (memaddr[3:0] == 4'h0) begin
                rd_data_s = {ovf_r, 2'b00, lvl_sat_s};
            end else begin
                rd_data_s = regs_r[memaddr[3:0]];
            end
        end else if (memaddr == ADDR_A100) begin
            rd_data_s = func_code_r;
        end else begin
            rd_data_s = 8'h00;
        end
    end

    // Bus handshake: one ack per request, then wait for the MCU to release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            memack_r   <= 1'b0;
            memdatai_r <= 8'h00;
            req_addr_r <= 16'h0000;
            req_data_r <= 8'h00;
            req_wr_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    memack_r   <= 1'b0;
                    memdatai_r <= 8'h00;
                    if ((memwr || memrd) && hit_s) begin
                        state_r    <= ST_ACK;
                        memack_r   <= 1'b1;
                        req_addr_r <= memaddr;
                        req_data_r <= memdatao;
                        req_wr_r   <= memwr;
                        memdatai_r <= memwr ? 8'h00 : rd_data_s;
                    end
                end
                ST_ACK: begin
                    memack_r   <= 1'b0;
                    memdatai_r <= 8'h00;
                    state_r    <= ST_REL;
                end
                ST_REL: begin
                    memack_r   <= 1'b0;
                    memdatai_r <= 8'h00;
                    if (!memwr && !memrd) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    memack_r   <= 1'b0;
                    memdatai_r <= 8'h00;
                end
            endcase
        end
    end

    // Classify the write being acknowledged this cycle
    always_comb begin
        ack_wr_s   = (state_r == ST_ACK) && req_wr_r;
        hdr_s      = '0;
        hdr_s.data = req_data_r;
        trace_s    = 1'b0;
        ctrl_clr_s = 1'b0;
        if (ack_wr_s) begin
            if (req_addr_r[15:4] == ADDR_REG_PAGE) begin
                if (req_addr_r[3:0] == 4'h0) begin
                    ctrl_clr_s = req_data_r[0];
                end else begin
                    trace_s    = 1'b1;
                    hdr_s.code = {1'b0, req_addr_r[3:0]};
                end
            end else if (req_addr_r == ADDR_A100) begin
                trace_s    = 1'b1;
                hdr_s.code = CODE_FUNC;
            end else if (req_addr_r == ADDR_D000) begin
                trace_s    = 1'b1;
                hdr_s.code = CODE_D000;
            end else if (req_addr_r == ADDR_E000) begin
                trace_s    = 1'b1;
                hdr_s.code = CODE_E000;
            end else begin
                trace_s = 1'b0;
            end
        end else begin
            trace_s = 1'b0;
        end
        pop_s  = trc_ready && !fifo_empty_s;
        drop_s = trace_s && fifo_full_s && !pop_s;
    end

    // Parameter registers and function code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs_r[i] <= 8'h00;
            end
            func_code_r <= 8'h00;
        end else if (ack_wr_s) begin
            if ((req_addr_r[15:4] == ADDR_REG_PAGE) && (req_addr_r[3:0] != 4'h0)) begin
                regs_r[req_addr_r[3:0]] <= req_data_r;
            end
            if (req_addr_r == ADDR_A100) begin
                func_code_r <= req_data_r;
            end
        end
    end

    // Free-running timestamp
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_r <= {TS_W{1'b0}};
        end else begin
            ts_r <= ts_r + TS_W'(1);
        end
    end

    // Overflow tracking; a clear from the control register beats a drop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 8'h00;
        end else if (ctrl_clr_s) begin
            ovf_r     <= 1'b0;
            ovf_cnt_r <= 8'h00;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
            if (ovf_cnt_r != 8'hFF) begin
                ovf_cnt_r <= ovf_cnt_r + 8'h01;
            end
        end
    end

    pemcu_dbg_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (trace_s),
        .din   ({hdr_s, ts_r}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .level (fifo_level_s)
    );

endmodule

// File: tb/tb_pemcu_dbg_mailbox.sv
// Self-checking bench for pemcu_dbg_mailbox: a table of single accesses plus
// hand-written sequences for timing, overflow, simultaneous push/pop and reset.
module tb_pemcu_dbg_mailbox;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] memaddr;
    logic        memwr;
    logic        memrd;
    logic [7:0]  memdatao;
    logic [7:0]  memdatai;
    logic        memack;
    logic        hit;
    logic        trc_valid;
    logic        trc_ready;
    logic [4:0]  trc_code;
    logic [7:0]  trc_data;
    logic [15:0] trc_ts;
    logic        ovf;
    logic [7:0]  ovf_cnt;

    int errors = 0;
    int checks = 0;
    logic [15:0] tb_ts;

    typedef struct packed {
        logic [15:0] addr;
        logic        wr;
        logic        rd;
        logic [7:0]  wdata;
        logic        exp_ack;
        logic        chk_rd;
        logic [7:0]  exp_rdata;
        logic        exp_push;
        logic [4:0]  exp_code;
    } vec_t;

    vec_t vecs [15];

    pemcu_dbg_mailbox #(.FIFO_DEPTH(16), .TS_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .memaddr   (memaddr),
        .memwr     (memwr),
        .memrd     (memrd),
        .memdatao  (memdatao),
        .memdatai  (memdatai),
        .memack    (memack),
        .hit       (hit),
        .trc_valid (trc_valid),
        .trc_ready (trc_ready),
        .trc_code  (trc_code),
        .trc_data  (trc_data),
        .trc_ts    (trc_ts),
        .ovf       (ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Reference cycle count since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) tb_ts <= 16'h0000;
        else     tb_ts <= tb_ts + 16'h0001;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic access(input logic [15:0] a, input logic w, input logic r,
                          input logic [7:0] d, input int hold,
                          output logic h, output int acks,
                          output logic [7:0] rdata, output logic [15:0] ats);
        @(posedge clk); #1;
        memaddr = a; memwr = w; memrd = r; memdatao = d;
        #1 h = hit;
        acks = 0; rdata = 8'h00; ats = 16'h0000;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (memack) begin
                acks++;
                rdata = memdatai;
                ats = tb_ts;
            end
        end
        memwr = 1'b0; memrd = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic pop_expect(input string name, input logic [4:0] code, input logic [7:0] data);
        check({name, " valid"}, 32'(trc_valid), 32'h1);
        check({name, " code"}, 32'(trc_code), 32'(code));
        check({name, " data"}, 32'(trc_data), 32'(data));
        trc_ready = 1'b1;
        @(posedge clk); #1;
        trc_ready = 1'b0;
    endtask

    logic        h;
    int          acks;
    int          first_ack;
    logic [7:0]  rdata;
    logic [15:0] ats;

    initial begin
        vecs[0]  = '{16'hF109, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 5'h09};
        vecs[1]  = '{16'hF109, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h5A, 1'b0, 5'h00};
        vecs[2]  = '{16'hA100, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 8'h00, 1'b1, 5'h10};
        vecs[3]  = '{16'hA100, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 5'h00};
        vecs[4]  = '{16'hD000, 1'b1, 1'b0, 8'h77, 1'b1, 1'b0, 8'h00, 1'b1, 5'h11};
        vecs[5]  = '{16'hE000, 1'b1, 1'b0, 8'h88, 1'b1, 1'b0, 8'h00, 1'b1, 5'h12};
        vecs[6]  = '{16'hD000, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h00};
        vecs[7]  = '{16'hF10F, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 5'h0F};
        vecs[8]  = '{16'hF10F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 5'h00};
        vecs[9]  = '{16'h1234, 1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 8'h00, 1'b0, 5'h00};
        vecs[10] = '{16'hF100, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h00};
        vecs[11] = '{16'hF101, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 5'h01};
        vecs[12] = '{16'hF101, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 5'h00};
        vecs[13] = '{16'hF110, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 5'h00};
        vecs[14] = '{16'hE000, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 5'h00};

        rst = 1'b1; memaddr = 16'h0000; memwr = 1'b0; memrd = 1'b0;
        memdatao = 8'h00; trc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset memack", 32'(memack), 32'h0);
        check("reset memdatai", 32'(memdatai), 32'h0);
        check("reset trc_valid", 32'(trc_valid), 32'h0);
        check("reset trc_code", 32'(trc_code), 32'h0);
        check("reset trc_data", 32'(trc_data), 32'h0);
        check("reset trc_ts", 32'(trc_ts), 32'h0);
        check("reset ovf", 32'(ovf), 32'h0);
        check("reset ovf_cnt", 32'(ovf_cnt), 32'h0);
        rst = 1'b0;

        // Write held for four cycles: one ack at N+1, entry visible at N+2
        @(posedge clk); #1;
        memaddr = 16'hF109; memwr = 1'b1; memdatao = 8'h5A;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (memack) acks++;
            if (i == 0) begin
                ats = tb_ts;
                check("t1 ack at N+1", 32'(memack), 32'h1);
                check("t1 valid at N+1", 32'(trc_valid), 32'h0);
            end
            if (i == 1) begin
                check("t1 valid at N+2", 32'(trc_valid), 32'h1);
            end
        end
        check("t1 single ack", 32'(acks), 32'h1);
        memwr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t1 ts", 32'(trc_ts), 32'(ats));
        pop_expect("t1 entry", 5'h09, 8'h5A);
        check("t1 empty after pop", 32'(trc_valid), 32'h0);

        // Table of single accesses with the FIFO drained after each
        for (int k = 0; k < 15; k++) begin
            access(vecs[k].addr, vecs[k].wr, vecs[k].rd, vecs[k].wdata, 3, h, acks, rdata, ats);
            check($sformatf("vec%0d hit", k), 32'(h), 32'(vecs[k].exp_ack));
            check($sformatf("vec%0d acks", k), 32'(acks), 32'(vecs[k].exp_ack));
            if (vecs[k].chk_rd) begin
                check($sformatf("vec%0d rdata", k), 32'(rdata), 32'(vecs[k].exp_rdata));
            end
            if (vecs[k].exp_push) begin
                check($sformatf("vec%0d ts", k), 32'(trc_ts), 32'(ats));
                pop_expect($sformatf("vec%0d entry", k), vecs[k].exp_code, vecs[k].wdata);
            end
            check($sformatf("vec%0d fifo empty", k), 32'(trc_valid), 32'h0);
        end

        // Two entries queued without popping; level read back through F100
        access(16'hA100, 1'b1, 1'b0, 8'h03, 2, h, acks, rdata, ats);
        access(16'hD000, 1'b1, 1'b0, 8'h77, 2, h, acks, rdata, ats);
        access(16'hF100, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("t2 level read", 32'(rdata), 32'h02);
        pop_expect("t2 first", 5'h10, 8'h03);
        pop_expect("t2 second", 5'h11, 8'h77);

        // Overflow: 17 writes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            access(16'hF10A, 1'b1, 1'b0, 8'(i), 2, h, acks, rdata, ats);
        end
        check("t3 ovf", 32'(ovf), 32'h1);
        check("t3 ovf_cnt", 32'(ovf_cnt), 32'h1);
        access(16'hF100, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("t3 status read", 32'(rdata), 32'h90);

        // Full FIFO with a pop in the ACK cycle of a traced write: no drop
        @(posedge clk); #1;
        memaddr = 16'hF101; memwr = 1'b1; memdatao = 8'h42;
        @(posedge clk); #1;
        check("t5 ack", 32'(memack), 32'h1);
        trc_ready = 1'b1;
        @(posedge clk); #1;
        trc_ready = 1'b0;
        memwr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t5 ovf_cnt unchanged", 32'(ovf_cnt), 32'h1);
        access(16'hF100, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("t5 level still 16", 32'(rdata), 32'h90);

        // Drop counter saturates
        for (int i = 0; i < 260; i++) begin
            access(16'hF10B, 1'b1, 1'b0, 8'hEE, 2, h, acks, rdata, ats);
        end
        check("sat ovf_cnt", 32'(ovf_cnt), 32'hFF);
        access(16'hF100, 1'b1, 1'b0, 8'hFE, 2, h, acks, rdata, ats);
        check("ctrl bit0=0 keeps ovf", 32'(ovf), 32'h1);
        check("ctrl bit0=0 keeps cnt", 32'(ovf_cnt), 32'hFF);
        access(16'hF100, 1'b1, 1'b0, 8'h01, 2, h, acks, rdata, ats);
        check("clear ack", 32'(acks), 32'h1);
        check("clear ovf", 32'(ovf), 32'h0);
        check("clear ovf_cnt", 32'(ovf_cnt), 32'h0);
        access(16'hF100, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("clear status read", 32'(rdata), 32'h10);
        for (int i = 1; i < 16; i++) begin
            pop_expect($sformatf("drain%0d", i), 5'h0A, 8'(i));
        end
        pop_expect("drain last", 5'h01, 8'h42);
        check("drain empty", 32'(trc_valid), 32'h0);

        // Reset asserted during ACK, request kept held through release
        access(16'hF102, 1'b1, 1'b0, 8'h66, 2, h, acks, rdata, ats);
        @(posedge clk); #1;
        memaddr = 16'hF103; memwr = 1'b1; memdatao = 8'h99;
        @(posedge clk); #1;
        check("t6 ack before reset", 32'(memack), 32'h1);
        #1 rst = 1'b1;
        #1;
        check("t6 memack in reset", 32'(memack), 32'h0);
        check("t6 fifo empty in reset", 32'(trc_valid), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0; first_ack = -1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (memack) begin
                acks++;
                if (first_ack < 0) first_ack = i;
            end
        end
        check("t6 acks after release", 32'(acks), 32'h1);
        check("t6 ack timing", 32'(first_ack), 32'h0);
        memwr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        pop_expect("t6 entry", 5'h03, 8'h99);
        check("t6 only one entry", 32'(trc_valid), 32'h0);
        access(16'hF102, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("t6 reg cleared", 32'(rdata), 32'h00);
        access(16'hF103, 1'b0, 1'b1, 8'h00, 2, h, acks, rdata, ats);
        check("t6 reg rewritten", 32'(rdata), 32'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
